// File: rtl/wide_slice_serializer.sv
// -----------------------------------------------------------------------------
// wide_slice_serializer
//
// Takes one wide result word (NSLICE slices of SLICE_W bits) and emits it as
// NSLICE consecutive beats, least-significant slice first. A single holding
// register stores the word. When the last beat is taken, a new word can be
// loaded in the same cycle, so a continuous input stream produces a continuous
// beat stream.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// when valid && ready are both high. Once out_valid is raised, it stays high
// and out_data/out_idx/out_last stay stable until the beat is taken. in_ready
// depends on out_ready combinationally, but only in the last-beat refill case.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream word present on in_data
//   in_ready   - block accepts the word this cycle
//   in_data    - wide word; slice k = bits [SLICE_W*k +: SLICE_W]
//   out_valid  - out_data holds a valid slice
//   out_ready  - downstream takes the slice
//   out_data   - current slice
//   out_idx    - index of the current slice (0..NSLICE-1)
//   out_last   - current slice is the final one of the word
//   word_cnt   - number of fully emitted words (wraps)
//   dbg_state  - FSM state for observation: 0 = IDLE, 1 = SEND
// -----------------------------------------------------------------------------
module wide_slice_serializer #(
    parameter  int SLICE_W = 41,
    parameter  int NSLICE  = 3,
    localparam int IDX_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int DATA_W  = SLICE_W * NSLICE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic [63:0]        word_cnt,
    output logic               dbg_state
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,   // holding register empty
        SEND = 1'b1    // holding register full, emitting beats
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   hold_q;
    logic                in_hs;
    logic                out_hs;

    // All outputs decode directly from registers, so they are glitch-free
    // with respect to the inputs. The one exception is in_ready, which must
    // see out_ready to allow a refill in the same cycle as the last beat.
    assign out_valid = (state_q == SEND);
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_data  = hold_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign dbg_state = (state_q == SEND);

    // A new word is accepted when the register is empty, or when the last
    // beat is leaving in this cycle.
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            word_cnt <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        hold_q  <= in_data;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end

                SEND: begin
                    if (out_hs) begin
                        if (idx_q == LAST_IDX) begin
                            // Word completes. The counter wraps naturally at 2^64.
                            word_cnt <= word_cnt + 64'd1;
                            idx_q    <= '0;
                            if (in_hs) begin
                                // Back-to-back refill: no idle cycle between words.
                                hold_q  <= in_data;
                                state_q <= SEND;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

endmodule
